// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end for the DLX pipeline.
//
// It issues pipelined fetch requests to a variable-latency instruction memory.
// It buffers each returned instruction, together with its PC, in a DEPTH-entry
// in-order queue that decode drains through a valid/ready handshake. A redirect
// from ID flushes the queue. Every response still outstanding at that moment is
// later thrown away by a drop counter.
//
// Ports
//   clk, initPC                 clock, synchronous active-high reset
//   imem_req/addr/ready         request channel to instruction memory
//   imem_rvalid/rdata           in-order response channel
//   redirect, redirect_pc       taken branch/jump target from ID
//   out_valid/inst/pc/ready     queue head towards decode
//   q_count                     current queue occupancy
module fetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic                       clk,
    input  logic                       initPC,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic                       imem_ready,
    input  logic                       imem_rvalid,
    input  logic [INST_W-1:0]          imem_rdata,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       out_valid,
    output logic [INST_W-1:0]          out_inst,
    output logic [ADDR_W-1:0]          out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     q_count
);

    localparam int CW = $clog2(DEPTH) + 1;   // counters hold 0..DEPTH
    localparam int PW = $clog2(DEPTH);       // queue pointers wrap naturally
    localparam logic [CW-1:0]     CNT_FULL = CW'(DEPTH);
    localparam logic [CW:0]       CREDITS  = (CW+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q,  resp_pc_d;
    logic [CW-1:0]     count_q,    count_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     drop_q,     drop_d;
    logic [PW-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q,   rd_ptr_d;

    logic [INST_W-1:0] inst_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];

    logic [CW:0] used;
    logic        accept, push, pop;

    // Queued entries plus outstanding requests never exceed DEPTH. This
    // reserves a slot for every response before the request is sent.
    assign used      = {1'b0, count_q} + {1'b0, inflight_q};
    assign imem_req  = !initPC && !redirect && (used < CREDITS);
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req && imem_ready;

    assign out_valid = (count_q != '0);
    assign out_inst  = inst_q[rd_ptr_q];
    assign out_pc    = pc_q[rd_ptr_q];
    assign q_count   = count_q;

    // A response arriving in a redirect cycle is stale, as is any response
    // that is still owed to the drop counter.
    assign push = !initPC && !redirect && imem_rvalid && (drop_q == '0);
    assign pop  = !redirect && out_valid && out_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        inflight_d = inflight_q - CW'(imem_rvalid);
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            // inflight counts every outstanding request, including ones that
            // are already owed to an earlier drop. So this value is correct on
            // its own, and a back-to-back redirect simply overwrites it.
            drop_d     = inflight_q - CW'(imem_rvalid);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + STEP;
                inflight_d = inflight_q + 1'b1 - CW'(imem_rvalid);
            end
            if (imem_rvalid && drop_q != '0)
                drop_d = drop_q - 1'b1;
            if (push) begin
                resp_pc_d = resp_pc_q + STEP;
                wr_ptr_d  = wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (initPC) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // The storage needs no reset, because occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_ptr_q] <= imem_rdata;
            pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (initPC)
        !(push && count_q == CNT_FULL));
    a_credit: assert property (@(posedge clk) disable iff (initPC)
        used <= CREDITS);
    a_drop: assert property (@(posedge clk) disable iff (initPC)
        drop_q <= inflight_q);

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        initPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;
    logic [2:0]  q_count;

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk(clk), .initPC(initPC),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_ready(out_ready), .q_count(q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a memory that returns outstanding requests in order,
    // each tagged with the redirect epoch in which it was issued. The model
    // also keeps the expected output queue as a list of PCs.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        memq[$];
    logic [31:0] mq[$];
    logic [31:0] popped[$];
    int          epoch, cyc, last_due, lat_lo, lat_hi, rdy_pct;
    logic [31:0] next_fetch;
    int          n_cmp, n_err;
    logic        seen_200;

    logic        obs_req, obs_valid, obs_rv;
    logic [31:0] obs_addr, obs_pc;
    logic [2:0]  obs_qc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Run one clock cycle: drive inputs, check the DUT against the model,
    // then advance the model across the edge.
    task automatic step(input logic rd, input logic [31:0] rpc, input logic ord);
        logic rv, exp_req, exp_valid, acc;
        req_t r;
        int   due;
        @(negedge clk);
        initPC      = 1'b0;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = ord;
        imem_ready  = ($urandom_range(99) < rdy_pct);
        rv          = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(memq[0].addr) : $urandom();
        #1;
        obs_req = imem_req; obs_addr = imem_addr; obs_valid = out_valid;
        obs_pc  = out_pc;   obs_qc   = q_count;   obs_rv    = rv;
        if (imem_req === 1'b1 && imem_addr == 32'h200) seen_200 = 1'b1;

        exp_req   = !rd && (mq.size() + memq.size() < DEPTH);
        exp_valid = (mq.size() != 0);
        n_cmp++;
        if (imem_req !== exp_req) begin
            n_err++; $display("FAIL imem_req cyc=%0d got=%b want=%b", cyc, imem_req, exp_req);
        end
        if (exp_req) begin
            n_cmp++;
            if (imem_addr !== next_fetch) begin
                n_err++; $display("FAIL imem_addr cyc=%0d got=%h want=%h", cyc, imem_addr, next_fetch);
            end
        end
        n_cmp++;
        if (out_valid !== exp_valid) begin
            n_err++; $display("FAIL out_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_valid);
        end
        if (exp_valid) begin
            n_cmp++;
            if (out_pc !== mq[0] || out_inst !== mem_word(mq[0])) begin
                n_err++;
                $display("FAIL head cyc=%0d got pc=%h inst=%h want pc=%h inst=%h",
                         cyc, out_pc, out_inst, mq[0], mem_word(mq[0]));
            end
        end
        n_cmp++;
        if (q_count !== 3'(mq.size())) begin
            n_err++; $display("FAIL q_count cyc=%0d got=%0d want=%0d", cyc, q_count, mq.size());
        end

        acc = exp_req && imem_ready;
        if (!rd && exp_valid && ord) begin
            popped.push_back(out_pc);
            void'(mq.pop_front());
        end
        if (rv) begin
            r = memq.pop_front();
            if (!rd && r.epoch == epoch) mq.push_back(r.addr);
        end
        if (rd) begin
            mq.delete();
            epoch++;
            next_fetch = rpc;
        end
        if (acc) begin
            due = cyc + $urandom_range(lat_hi, lat_lo);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{next_fetch, epoch, due});
            next_fetch += 32'd4;
        end
        @(posedge clk);
        cyc++;
    endtask

    // Two reset cycles, with a redirect and handshakes driven to show that
    // reset wins. Responses still in flight are forgotten by both sides.
    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            initPC = 1'b1; redirect = 1'b1; redirect_pc = 32'h55;
            out_ready = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b0;
            #1;
            n_cmp++;
            if (imem_req !== 1'b0) begin
                n_err++; $display("FAIL reset_req got=%b want=0", imem_req);
            end
            @(posedge clk);
            cyc++;
        end
        memq.delete(); mq.delete(); popped.delete();
        epoch++; next_fetch = 32'h0; last_due = 0;
    endtask

    task automatic test_reset();
        lat_lo = 1; lat_hi = 1; rdy_pct = 100;
        do_reset();
        step(1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (obs_qc !== 3'd0 || obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state got qc=%0d v=%b req=%b addr=%h want 0 0 1 0",
                     obs_qc, obs_valid, obs_req, obs_addr);
        end
    endtask

    task automatic test_stream();
        int first, bubbles;
        lat_lo = 1; lat_hi = 1; rdy_pct = 100;
        do_reset();
        first = -1; bubbles = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (obs_valid && first < 0) first = i;
            else if (!obs_valid && first >= 0) bubbles++;
        end
        n_cmp++;
        if (first != 2) begin
            n_err++; $display("FAIL stream_first got=%0d want=2", first);
        end
        n_cmp++;
        if (bubbles != 0) begin
            n_err++; $display("FAIL stream_bubbles got=%0d want=0", bubbles);
        end
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (popped[i] !== 32'(4 * i)) begin
                n_err++; $display("FAIL stream_pc[%0d] got=%h want=%h", i, popped[i], 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        lat_lo = 1; lat_hi = 1; rdy_pct = 100;
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0);
        n_cmp++;
        if (obs_qc !== 3'd4 || obs_req !== 1'b0) begin
            n_err++; $display("FAIL stall_full got qc=%0d req=%b want 4 0", obs_qc, obs_req);
        end
        step(1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (popped.size() != 1 || popped[0] !== 32'h0) begin
            n_err++; $display("FAIL stall_pop got n=%0d want one pop of pc 0", popped.size());
        end
        step(1'b0, 32'h0, 1'b0);
        n_cmp++;
        if (obs_req !== 1'b1 || obs_addr !== 32'h10) begin
            n_err++; $display("FAIL stall_resume got req=%b addr=%h want 1 00000010", obs_req, obs_addr);
        end
        step(1'b0, 32'h0, 1'b0);
        n_cmp++;
        if (obs_req !== 1'b0) begin
            n_err++; $display("FAIL stall_single got req=%b want 0", obs_req);
        end
    endtask

    task automatic test_redirect_stale();
        lat_lo = 3; lat_hi = 3; rdy_pct = 100;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (memq.size() != 3 || memq[1].addr != 32'h8 || memq[2].addr != 32'hC) begin
            n_err++; $display("FAIL stale_setup got outstanding=%0d want 3 (4,8,12)", memq.size());
        end
        popped.delete();
        step(1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (popped.size() == 0 || popped[0] !== 32'h100) begin
            n_err++;
            $display("FAIL stale_first got=%h want=00000100", popped.size() ? popped[0] : 32'hX);
        end
        foreach (popped[i]) begin
            n_cmp++;
            if (popped[i] == 32'h8 || popped[i] == 32'hC) begin
                n_err++; $display("FAIL stale_leak got pc=%h want none of 8/C", popped[i]);
            end
        end
    endtask

    task automatic test_redirect_collide();
        lat_lo = 1; lat_hi = 1; rdy_pct = 100;
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h40, 1'b1);
        n_cmp++;
        if (obs_valid !== 1'b1 || obs_rv !== 1'b1) begin
            n_err++; $display("FAIL collide_setup got v=%b rv=%b want 1 1", obs_valid, obs_rv);
        end
        step(1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (obs_qc !== 3'd0 || obs_req !== 1'b1 || obs_addr !== 32'h40) begin
            n_err++;
            $display("FAIL collide_after got qc=%0d req=%b addr=%h want 0 1 00000040",
                     obs_qc, obs_req, obs_addr);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_back_to_back();
        lat_lo = 1; lat_hi = 2; rdy_pct = 100;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
        popped.delete();
        seen_200 = 1'b0;
        step(1'b1, 32'h200, 1'b1);
        step(1'b1, 32'h300, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1);
        n_cmp++;
        if (seen_200 !== 1'b0) begin
            n_err++; $display("FAIL b2b_req200 got=%b want=0", seen_200);
        end
        n_cmp++;
        if (popped.size() < 2 || popped[0] !== 32'h300 || popped[1] !== 32'h304) begin
            n_err++; $display("FAIL b2b_stream got n=%0d want 300,304,...", popped.size());
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        want[0] = 32'hFFFFFFF8; want[1] = 32'hFFFFFFFC; want[2] = 32'h0;
        lat_lo = 1; lat_hi = 1; rdy_pct = 100;
        popped.delete();
        step(1'b1, 32'hFFFFFFF8, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (popped.size() <= i || popped[i] !== want[i]) begin
                n_err++; $display("FAIL wrap_pc[%0d] got n=%0d want=%h", i, popped.size(), want[i]);
            end
        end
    endtask

    task automatic test_random();
        logic rd, ord;
        lat_lo = 1; lat_hi = 4; rdy_pct = 70;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(999) < 5) do_reset();
            rd  = ($urandom_range(99) < 4);
            ord = ($urandom_range(99) < 60);
            step(rd, {$urandom_range(32'h3FFF_FFFF, 0), 2'b00}, ord);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; epoch = 0; cyc = 0; last_due = 0;
        next_fetch = 32'h0; seen_200 = 1'b0;
        initPC = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_stale();
        test_redirect_collide();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
